alu_serial_seq: RTL and testbench

ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

---
 rtl/alu_serial_seq.sv | 101 ++++++++++
 tb/tb_alu_serial_seq.sv | 129 ++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial AND/OR/ADD/SUB/SLT ALU built on a 1-bit slice and carry register
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       alu_sig,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             illegal
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, SLT_FIX, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] ra, rb;
  logic [2:0] op, code;
  logic [IW-1:0] idx;
  logic carry, sup, ai, bi, sum, co, rbit, last;
  always_comb begin
    sup = funct == 6'h24 || funct == 6'h25 || funct == 6'h20 || funct == 6'h22 || funct == 6'h2A;
    code = funct == 6'h24 ? 3'b000 : funct == 6'h25 ? 3'b001 : funct == 6'h20 ? 3'b010 :
           funct == 6'h22 ? 3'b110 : 3'b111;
    ai = ra[idx];
    bi = rb[idx] ^ op[2];
    sum = ai ^ bi ^ carry;
    co = (ai & bi) | (carry & (ai ^ bi));
    rbit = op[1] ? sum : op[0] ? (ai | rb[idx]) : (ai & rb[idx]);
    last = idx == IW'(WIDTH - 1);
  end
  assign zero = ~|result;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      op <= '0;
      idx <= '0;
      carry <= 1'b0;
      alu_sig <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      cout <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && sup) begin
            ra <= a;
            rb <= b;
            op <= code;
            idx <= '0;
            carry <= code[2];
            illegal <= 1'b0;
            alu_sig <= code;
            busy <= 1'b1;
            state <= RUN;
          end else if (start) begin
            illegal <= 1'b1;
            result <= '0;
            cout <= 1'b0;
            done <= 1'b1;
            busy <= 1'b1;
            alu_sig <= '0;
            state <= DONE;
          end
        end
        RUN: begin
          result[idx] <= rbit;
          carry <= co;
          idx <= last ? '0 : idx + 1'b1;
          if (last) begin
            cout <= op[1] & co;
            state <= op == 3'b111 ? SLT_FIX : DONE;
            done <= op != 3'b111;
            alu_sig <= op == 3'b111 ? op : 3'b000;
          end
        end
        SLT_FIX: begin
          result <= {{(WIDTH-1){1'b0}}, result[WIDTH-1]};
          done <= 1'b1;
          alu_sig <= '0;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: directed self-checking bench for alu_serial_seq
module tb_alu_serial_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [5:0] funct = '0;
  logic [31:0] a = '0, b = '0;
  logic [2:0] alu_sig;
  logic busy, done, cout, zero, illegal;
  logic [31:0] result;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  alu_serial_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct), .a(a), .b(b),
    .alu_sig(alu_sig), .busy(busy), .done(done), .result(result),
    .cout(cout), .zero(zero), .illegal(illegal)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                        input int lat, input logic [31:0] res, input logic co, input logic ill, input logic [2:0] sig);
    int n;
    @(negedge clk);
    start = 1'b1; funct = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_sig"}, alu_sig, sig);
    wait_done(n);
    check({tag, "_lat"}, n, lat);
    check({tag, "_res"}, result, res);
    check({tag, "_cout"}, cout, co);
    check({tag, "_zero"}, zero, res == 0);
    check({tag, "_ill"}, illegal, ill);
    check({tag, "_busy"}, busy, 1);
    @(posedge clk); #1;
    check({tag, "_done1"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_hold"}, result, res);
  endtask
  initial begin
    int n, seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", result, 0);
    check("rst_zero", zero, 1);
    check("rst_sig", alu_sig, 0);
    check("rst_ill", illegal, 0);
    @(negedge clk) rst = 1'b0;
    run_op("add_wrap", 6'h20, 32'hFFFF_FFFF, 32'h1, 33, 32'h0, 1, 0, 3'b010);
    run_op("sub_neg", 6'h22, 32'h3, 32'h5, 33, 32'hFFFF_FFFE, 0, 0, 3'b110);
    run_op("slt_lt", 6'h2A, 32'h3, 32'h5, 34, 32'h1, 0, 0, 3'b111);
    run_op("slt_ovf", 6'h2A, 32'h8000_0000, 32'h1, 34, 32'h0, 1, 0, 3'b111);
    run_op("and", 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 33, 32'hF000_F000, 0, 0, 3'b000);
    run_op("or", 6'h25, 32'hF0F0_F0F0, 32'hFF00_FF00, 33, 32'hFFF0_FFF0, 0, 0, 3'b001);
    run_op("illegal", 6'h27, 32'h1234, 32'h5678, 1, 32'h0, 0, 1, 3'b000);
    run_op("add_clr", 6'h20, 32'h2, 32'h3, 33, 32'h5, 0, 0, 3'b010);
    run_op("sub_pos", 6'h22, 32'h5, 32'h3, 33, 32'h2, 1, 0, 3'b110);
    // start while busy must not disturb the running ADD
    @(negedge clk);
    start = 1'b1; funct = 6'h20; a = 32'hA; b = 32'h14;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    start = 1'b1; funct = 6'h22; a = 32'h7; b = 32'h7;
    @(negedge clk) start = 1'b0;
    #1;
    n = 10;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_ign_lat", n, 33);
    check("busy_ign_res", result, 32'h1E);
    // start during done is ignored, accepted on the following IDLE cycle
    @(negedge clk);
    start = 1'b1; funct = 6'h20; a = 32'h1; b = 32'h1;
    @(posedge clk); #1;
    check("done_start_ign", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("done_start_acc", busy, 1);
    wait_done(n);
    check("done_start_lat", n, 33);
    check("done_start_res", result, 32'h2);
    @(posedge clk); #1;
    // reset mid-RUN aborts with no done pulse
    @(negedge clk);
    start = 1'b1; funct = 6'h20; a = 32'h11; b = 32'h22;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_res", result, 0);
    check("abort_cout", cout, 0);
    check("abort_zero", zero, 1);
    check("abort_sig", alu_sig, 0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort_nodone", seen, 0);
    // reset wins over start in the same cycle
    @(negedge clk);
    rst = 1'b1; start = 1'b1; funct = 6'h20;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_prio_busy", busy, 0);
    check("rst_prio_sig", alu_sig, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
